updn_count_arbiter: RTL and testbench

Shares one modulo-CNT_LENGTH up/down counter between two requesters, A and B. Each requester asks for a run of N single steps in one direction. The block grants one requester at a time using round-robin priority, steps the shared counter once per cycle until the run is complete, then pulses that requester's done flag. The counter value persists between runs, so both requesters see one shared position register, such as a ring index or turntable position.

---
 rtl/updn_pkg.sv | 21 ++
 rtl/mod_updn_core.sv | 40 ++++
 rtl/updn_count_arbiter.sv | 121 ++++++++++++
 tb/tb_updn_count_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/updn_pkg.sv
// Shared types and constants for the up/down counter arbiter.
package updn_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_e;

    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/mod_updn_core.sv
// Modulo-CNT_LENGTH up/down counter; steps once per enabled cycle.
module mod_updn_core
    import updn_pkg::*;
#(
    parameter int CNT_LENGTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updn,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] TOP = CNT_W'(CNT_LENGTH - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            if (updn) begin
                count_d = (count_q == TOP) ? '0 : count_q + 1'b1;
            end else begin
                count_d = (count_q == '0) ? TOP : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updn_count_arbiter.sv
// Round-robin arbiter sharing one modulo up/down counter between A and B.
module updn_count_arbiter
    import updn_pkg::*;
#(
    parameter int CNT_LENGTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             dir_a,
    input  logic [CNT_W-1:0] steps_a,
    output logic             gnt_a,
    output logic             done_a,
    input  logic             req_b,
    input  logic             dir_b,
    input  logic [CNT_W-1:0] steps_b,
    output logic             gnt_b,
    output logic             done_b,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    state_e           state_q;
    req_id_e          owner_q;
    req_id_e          prio_q;
    logic             dir_q;
    logic [CNT_W-1:0] rem_q;
    logic             gnt_a_q;
    logic             gnt_b_q;
    logic             done_a_q;
    logic             done_b_q;
    logic             busy_q;

    req_id_e          win;
    logic             win_dir;
    logic [CNT_W-1:0] win_steps;

    // Winner only matters in IDLE; prio_q breaks ties.
    always_comb begin
        win = REQ_A;
        if (req_a && req_b) begin
            win = prio_q;
        end else if (req_b) begin
            win = REQ_B;
        end
        win_dir   = (win == REQ_B) ? dir_b : dir_a;
        win_steps = (win == REQ_B) ? steps_b : steps_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= REQ_A;
            prio_q   <= REQ_A;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        owner_q <= win;
                        prio_q  <= other_id(win);
                        dir_q   <= win_dir;
                        rem_q   <= win_steps;
                        gnt_a_q <= (win == REQ_A);
                        gnt_b_q <= (win == REQ_B);
                        busy_q  <= 1'b1;
                        if (win_steps == '0) begin
                            state_q  <= DONE;
                            done_a_q <= (win == REQ_A);
                            done_b_q <= (win == REQ_B);
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_q  <= DONE;
                        done_a_q <= (owner_q == REQ_A);
                        done_b_q <= (owner_q == REQ_B);
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    done_a_q <= 1'b0;
                    done_b_q <= 1'b0;
                    gnt_a_q  <= 1'b0;
                    gnt_b_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    mod_updn_core #(
        .CNT_LENGTH(CNT_LENGTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == RUN),
        .updn (dir_q),
        .count(count)
    );

    assign gnt_a  = gnt_a_q;
    assign gnt_b  = gnt_b_q;
    assign done_a = done_a_q;
    assign done_b = done_b_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_updn_count_arbiter.sv
// Directed bench: two instances (modulus 8 and 32) share one stimulus.
module tb_updn_count_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a, dir_a, req_b, dir_b;
    logic [4:0] steps_a, steps_b;

    logic       gnt_a8, done_a8, gnt_b8, done_b8, busy8;
    logic [4:0] count8;
    logic       gnt_a32, done_a32, gnt_b32, done_b32, busy32;
    logic [4:0] count32;

    int npass;
    int ntotal;
    int m8;
    int m32;

    updn_count_arbiter #(.CNT_LENGTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .dir_a(dir_a), .steps_a(steps_a),
        .gnt_a(gnt_a8), .done_a(done_a8),
        .req_b(req_b), .dir_b(dir_b), .steps_b(steps_b),
        .gnt_b(gnt_b8), .done_b(done_b8),
        .count(count8), .busy(busy8)
    );

    updn_count_arbiter #(.CNT_LENGTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .dir_a(dir_a), .steps_a(steps_a),
        .gnt_a(gnt_a32), .done_a(done_a32),
        .req_b(req_b), .dir_b(dir_b), .steps_b(steps_b),
        .gnt_b(gnt_b32), .done_b(done_b32),
        .count(count32), .busy(busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        ntotal++;
        if (obs === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_model(input bit up);
        if (up) begin
            m8  = (m8 + 1) % 8;
            m32 = (m32 + 1) % 32;
        end else begin
            m8  = (m8 + 7) % 8;
            m32 = (m32 + 31) % 32;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt_a"}, int'(gnt_a8), 0);
        chk({tag, "_gnt_b"}, int'(gnt_b8), 0);
        chk({tag, "_done"}, int'(done_a8 | done_b8), 0);
        chk({tag, "_busy"}, int'(busy8), 0);
        chk({tag, "_cnt8"}, int'(count8), m8);
        chk({tag, "_cnt32"}, int'(count32), m32);
    endtask

    // One complete run by a single requester, checked every cycle.
    task automatic run(input string tag, input bit who_b, input bit up, input int n);
        logic done_own;
        if (who_b) begin
            req_b = 1'b1; dir_b = up; steps_b = 5'(n);
        end else begin
            req_a = 1'b1; dir_a = up; steps_a = 5'(n);
        end
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
        done_own = who_b ? done_b8 : done_a8;
        chk({tag, "_acc_gnt_a"}, int'(gnt_a8), int'(!who_b));
        chk({tag, "_acc_gnt_b"}, int'(gnt_b8), int'(who_b));
        chk({tag, "_acc_busy"}, int'(busy8), 1);
        chk({tag, "_acc_done"}, int'(done_own), int'(n == 0));
        chk({tag, "_acc_cnt8"}, int'(count8), m8);
        for (int i = 1; i <= n; i++) begin
            tick();
            step_model(up);
            done_own = who_b ? done_b8 : done_a8;
            chk({tag, "_cnt8"}, int'(count8), m8);
            chk({tag, "_cnt32"}, int'(count32), m32);
            chk({tag, "_done"}, int'(done_own), int'(i == n));
            chk({tag, "_dn32"}, int'(who_b ? done_b32 : done_a32), int'(i == n));
            chk({tag, "_other_gnt"}, int'(who_b ? gnt_a8 : gnt_b8), 0);
        end
        tick();
        chk_idle({tag, "_end"});
    endtask

    initial begin
        npass = 0; ntotal = 0; m8 = 0; m32 = 0;
        rst = 1'b1;
        req_a = 1'b0; dir_a = 1'b0; steps_a = '0;
        req_b = 1'b0; dir_b = 1'b0; steps_b = '0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        run("a_up5", 1'b0, 1'b1, 5);
        run("a_dn4", 1'b0, 1'b0, 4);
        run("b_dn3", 1'b1, 1'b0, 3);
        run("a_zero", 1'b0, 1'b1, 0);
        run("b_zero", 1'b1, 1'b0, 0);

        // Reset two steps into a six-step run: no done, count cleared.
        req_a = 1'b1; dir_a = 1'b1; steps_a = 5'd6;
        tick();
        req_a = 1'b0;
        tick();
        tick();
        step_model(1'b1);
        step_model(1'b1);
        chk("mid_cnt8", int'(count8), m8);
        rst = 1'b1;
        #1;
        m8 = 0; m32 = 0;
        chk_idle("mid_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_done", int'(done_a8 | done_b8), 0);
            chk("post_rst_cnt", int'(count8), 0);
        end

        // Simultaneous requests after reset: A first, B waits its turn.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req_a = 1'b1; dir_a = 1'b1; steps_a = 5'd2;
        req_b = 1'b1; dir_b = 1'b0; steps_b = 5'd1;
        tick();
        req_a = 1'b0;
        chk("both_gnt_a", int'(gnt_a8), 1);
        chk("both_gnt_b", int'(gnt_b8), 0);
        tick();
        chk("both_cnt1", int'(count8), 1);
        chk("both_gnt_b_wait", int'(gnt_b8), 0);
        tick();
        chk("both_cnt2", int'(count8), 2);
        chk("both_done_a", int'(done_a8), 1);
        chk("both_done_b_q", int'(done_b8), 0);
        tick();
        chk("both_idle_gnt_a", int'(gnt_a8), 0);
        chk("both_idle_gnt_b", int'(gnt_b8), 0);
        chk("both_idle_busy", int'(busy8), 0);
        tick();
        req_b = 1'b0;
        chk("both_b_gnt", int'(gnt_b8), 1);
        chk("both_b_gnt_a", int'(gnt_a8), 0);
        tick();
        chk("both_b_cnt8", int'(count8), 1);
        chk("both_b_cnt32", int'(count32), 1);
        chk("both_b_done", int'(done_b8), 1);
        tick();
        m8 = 1; m32 = 1;
        chk_idle("both_end");

        // 33 up steps from zero: wraps 31->0 at modulus 32, ends at 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m8 = 0; m32 = 0;
        tick();
        run("a_up33", 1'b0, 1'b1, 31);
        run("a_up2", 1'b0, 1'b1, 2);
        chk("wrap32_final", int'(count32), 1);
        chk("wrap8_final", int'(count8), 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
